uart_tx_fsm: RTL and testbench
==============================

# uart_tx_fsm

Frame sequencer for the UART transmitter. Accepts a one-cycle `Data_Valid` request, drives the serializer load and shift controls, and steps the 4:1 output mux select through start, data, optional parity and stop bits, one bit per `CLK` cycle (CLK is the TX baud clock). It also reports `busy` upstream. It sits between the UART TX top-level request interface and the serializer, parity calculator and output mux.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame (≥2).
- `CLK`  in  1  TX baud clock, all logic on rising edge.
- `RST`  in  1  synchronous, active-low reset.
- `Data_Valid`  in  1  frame request, sampled only in IDLE or on the last STOP cycle.
- `PAR_EN`  in  1  runtime parity enable, sampled with the accepted `Data_Valid`.
- `ser_load`  out  1  load `P_DATA` into the serializer and parity calculator.
- `ser_en`  out  1  serializer shifts one bit this cycle.
- `mux_sel`  out  2  output mux select: 00 = start (0), 01 = stop/idle (1), 10 = serial data, 11 = parity.
- `busy`  out  1  frame in progress.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. State, bit counter and latched parity enable (`par_q`) are registered.
- IDLE: `mux_sel`=01, `busy`=0. If `Data_Valid`=1, `ser_load`=1 (combinational, same cycle), `par_q`<=`PAR_EN`, next = START.
- START: `mux_sel`=00, `busy`=1, bit counter cleared. Next = DATA.
- DATA: `mux_sel`=10, `ser_en`=1, counter increments each cycle. When counter = DATA_WIDTH-1: next = PARITY if `par_q`, else STOP.
- PARITY: `mux_sel`=11. Next = STOP.
- STOP: `mux_sel`=01, `busy`=1. If `Data_Valid`=1: `ser_load`=1, `par_q`<=`PAR_EN`, next = START (back-to-back). Otherwise next = IDLE.
- `Data_Valid` in START, DATA or PARITY is ignored and not queued.
- Counter width is $clog2(DATA_WIDTH). It never wraps past DATA_WIDTH-1 and is held at 0 outside DATA.
- `PAR_EN` changes mid-frame have no effect.

## Timing
- Reset (`RST`=0 at an edge): state IDLE, counter 0, `par_q` 0. Outputs are `mux_sel`=01, `busy`=0, `ser_en`=0, `ser_load`=0 during reset.
- Reset mid-frame aborts the frame at the next edge. The line returns to idle-high and no partial bits follow.
- Outputs other than `ser_load` are Moore, decoded from the state register.
- Request accepted at edge k. The start bit is driven in cycle k+1, data bits in k+2..k+1+DATA_WIDTH, then parity (if enabled), then stop.
- Frame length is DATA_WIDTH+2 cycles, or DATA_WIDTH+3 with parity.
- Back-to-back: the next start bit immediately follows the single stop cycle, with no idle gap.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state and `par_q` are present, and `PAR_EN` selects per frame.
- Not defined: PARITY state and `par_q` are removed. The `PAR_EN` port remains but is ignored. DATA always goes to STOP, and `mux_sel`=11 is never driven.

## Structure
- Package `uart_tx_pkg` holds:
  - state enum `uart_tx_state_t`;
  - mux select constants `SEL_START`=2'b00, `SEL_STOP`=2'b01, `SEL_DATA`=2'b10, `SEL_PAR`=2'b11;
  - default `UART_DATA_WIDTH`=8.
- The bit counter is one natural sub-module, `uart_tx_bit_cnt`, with clear, enable and a `last` flag at DATA_WIDTH-1. The FSM and output decode stay in `uart_tx_fsm`.

## Test plan
- Reset mid-DATA: `RST`=0 while the counter is 3 -> next cycle shows IDLE with `mux_sel`=01, `busy`=0, `ser_en`=0.
- Single frame, `PAR_EN`=0, DATA_WIDTH=8, `Data_Valid` pulse at cycle 0:
  - `ser_load`=1 at cycle 0;
  - `mux_sel` = 00 at cycle 1, 10 for cycles 2–9 with `ser_en`=1, 01 at cycle 10;
  - `busy` 1 for cycles 1–10, 0 at cycle 11.
- Parity frame, `PAR_EN`=1: `mux_sel`=11 at cycle 10 and 01 at cycle 11, for an 11-cycle frame. With the macro undefined, the same stimulus gives the 10-cycle frame.
- Back-to-back: `Data_Valid`=1 during STOP -> `ser_load`=1 that cycle, and `mux_sel`=00 on the next cycle with `busy` staying 1.
- Ignored request: `Data_Valid` pulsed during DATA at counter 4 -> no `ser_load`, the frame completes unchanged, and the FSM returns to IDLE.
- `PAR_EN` toggled 1->0 mid-frame after acceptance with `PAR_EN`=1 -> parity bit still sent.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit frame sequencer.
// Optional parity support is compiled in with the UART_TX_PARITY_EN macro.
package uart_tx_pkg;

   localparam int UART_DATA_WIDTH = 8;

   localparam logic [1:0] SEL_START = 2'b00;
   localparam logic [1:0] SEL_STOP  = 2'b01;
   localparam logic [1:0] SEL_DATA  = 2'b10;
   localparam logic [1:0] SEL_PAR   = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_TX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_bit_cnt.sv
// Data-bit counter for the UART frame sequencer.
// Ports: CLK, RST (sync, active-low), clr, en; last = count at DATA_WIDTH-1.
module uart_tx_bit_cnt
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr,
   input  logic en,
   output logic last
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic [CW-1:0] cnt;

   // Counting past the last bit returns to zero so the count never
   // exceeds DATA_WIDTH-1, even for non-power-of-two widths.
   always_ff @(posedge CLK) begin
      if (!RST || clr || (en && last)) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign last = (cnt == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_fsm.sv
// UART TX frame sequencer: start, data, optional parity (UART_TX_PARITY_EN), stop.
// Ports: CLK, RST (sync, active-low), Data_Valid, PAR_EN -> ser_load, ser_en, mux_sel, busy.
module uart_tx_fsm
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       Data_Valid,
   input  logic       PAR_EN,
   output logic       ser_load,
   output logic       ser_en,
   output logic [1:0] mux_sel,
   output logic       busy
);

   uart_tx_state_t state;
   uart_tx_state_t state_nxt;
   logic           accept;
   logic           cnt_last;

`ifdef UART_TX_PARITY_EN
   logic par_q;
`else
   logic unused_par_en;
   assign unused_par_en = PAR_EN;
`endif

   uart_tx_bit_cnt #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_bit_cnt (
      .CLK (CLK),
      .RST (RST),
      .clr (state != ST_DATA),
      .en  (state == ST_DATA),
      .last(cnt_last)
   );

   // Requests are only taken when idle or on the final stop cycle.
   assign accept   = Data_Valid && ((state == ST_IDLE) || (state == ST_STOP));
   assign ser_load = RST && accept;

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:  state_nxt = accept ? ST_START : ST_IDLE;
         ST_START: state_nxt = ST_DATA;
         ST_DATA: begin
            if (cnt_last) begin
`ifdef UART_TX_PARITY_EN
               state_nxt = par_q ? ST_PARITY : ST_STOP;
`else
               state_nxt = ST_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: state_nxt = ST_STOP;
`endif
         ST_STOP:  state_nxt = accept ? ST_START : ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up
   // with the state register without extra decode delay.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state   <= ST_IDLE;
         mux_sel <= SEL_STOP;
         busy    <= 1'b0;
         ser_en  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         mux_sel <= SEL_STOP;
         busy    <= 1'b1;
         ser_en  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         if (accept) par_q <= PAR_EN;
`endif
         unique case (state_nxt)
            ST_IDLE:   busy    <= 1'b0;
            ST_START:  mux_sel <= SEL_START;
            ST_DATA: begin
               mux_sel <= SEL_DATA;
               ser_en  <= 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: mux_sel <= SEL_PAR;
`endif
            ST_STOP:   mux_sel <= SEL_STOP;
            default:   busy    <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench for uart_tx_fsm: frame-position model plus directed pins.
// Follows UART_TX_PARITY_EN for parity expectations.
module tb_uart_tx_fsm;

   localparam int W = 8;

   logic       CLK = 0;
   logic       RST;
   logic       Data_Valid;
   logic       PAR_EN;
   logic       ser_load;
   logic       ser_en;
   logic [1:0] mux_sel;
   logic       busy;

   int tests = 0;
   int fails = 0;
   bit started = 0;

   uart_tx_fsm #(.DATA_WIDTH(W)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .Data_Valid(Data_Valid),
      .PAR_EN    (PAR_EN),
      .ser_load  (ser_load),
      .ser_en    (ser_en),
      .mux_sel   (mux_sel),
      .busy      (busy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Model: position within the frame (-1 = idle). Position 0 is the
   // start bit, 1..W data, W+1 parity when enabled, last is stop.
   int pos = -1;
   bit par = 0;

   function automatic int last_pos(input bit p);
      return p ? W + 2 : W + 1;
   endfunction

   function automatic bit m_accept();
      return Data_Valid && ((pos == -1) || (pos == last_pos(par)));
   endfunction

   always @(posedge CLK) begin
      started <= 1;
      if (!RST) begin
         pos <= -1;
         par <= 0;
      end else if (m_accept()) begin
         pos <= 0;
`ifdef UART_TX_PARITY_EN
         par <= PAR_EN;
`else
         par <= 0;
`endif
      end else if (pos >= 0 && pos < last_pos(par)) begin
         pos <= pos + 1;
      end else begin
         pos <= -1;
      end
   end

   always @(negedge CLK) begin
      int e_sel;
      int e_busy;
      int e_en;
      if (started) begin
         e_busy = (pos >= 0) ? 1 : 0;
         e_en   = (pos >= 1 && pos <= W) ? 1 : 0;
         if (pos == 0) e_sel = 0;
         else if (pos >= 1 && pos <= W) e_sel = 2;
         else if (par && pos == W + 1) e_sel = 3;
         else e_sel = 1;
         chk("model_mux_sel", int'(mux_sel), e_sel);
         chk("model_busy", int'(busy), e_busy);
         chk("model_ser_en", int'(ser_en), e_en);
         chk("model_ser_load", int'(ser_load), (RST && m_accept()) ? 1 : 0);
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_ticks(input int n);
      Data_Valid = 0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      RST = 0;
      Data_Valid = 0;
      PAR_EN = 0;
      tick();
      tick();
      #2;
      chk("reset_mux_sel", int'(mux_sel), 1);
      chk("reset_busy", int'(busy), 0);
      chk("reset_ser_en", int'(ser_en), 0);
      RST = 1;
      idle_ticks(2);

      // Single frame, no parity.
      Data_Valid = 1;
      #2;
      chk("s_load_c0", int'(ser_load), 1);
      for (int c = 1; c <= 11; c++) begin
         tick();
         Data_Valid = 0;
         #2;
         if (c == 1) chk("s_sel_c1", int'(mux_sel), 0);
         if (c == 1) chk("s_busy_c1", int'(busy), 1);
         if (c == 5) chk("s_sel_c5", int'(mux_sel), 2);
         if (c == 9) chk("s_en_c9", int'(ser_en), 1);
         if (c == 10) chk("s_sel_c10", int'(mux_sel), 1);
         if (c == 10) chk("s_busy_c10", int'(busy), 1);
         if (c == 11) chk("s_busy_c11", int'(busy), 0);
      end
      idle_ticks(2);

      // Parity frame; PAR_EN drops right after acceptance.
      PAR_EN = 1;
      Data_Valid = 1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         Data_Valid = 0;
         PAR_EN = 0;
         #2;
`ifdef UART_TX_PARITY_EN
         if (c == 10) chk("p_sel_c10", int'(mux_sel), 3);
         if (c == 11) chk("p_sel_c11", int'(mux_sel), 1);
         if (c == 11) chk("p_busy_c11", int'(busy), 1);
         if (c == 12) chk("p_busy_c12", int'(busy), 0);
`else
         if (c == 10) chk("p_sel_c10", int'(mux_sel), 1);
         if (c == 11) chk("p_busy_c11", int'(busy), 0);
`endif
      end
      idle_ticks(2);

      // Back-to-back request during stop.
      Data_Valid = 1;
      tick();
      Data_Valid = 0;
      for (int c = 2; c <= 10; c++) tick();
      Data_Valid = 1;
      #2;
      chk("b2b_load", int'(ser_load), 1);
      tick();
      Data_Valid = 0;
      #2;
      chk("b2b_sel", int'(mux_sel), 0);
      chk("b2b_busy", int'(busy), 1);
      idle_ticks(13);

      // Request during DATA with counter at 4 is dropped.
      Data_Valid = 1;
      tick();
      Data_Valid = 0;
      for (int c = 2; c <= 6; c++) tick();
      Data_Valid = 1;
      #2;
      chk("ign_load", int'(ser_load), 0);
      tick();
      Data_Valid = 0;
      for (int c = 8; c <= 10; c++) tick();
      #2;
      chk("ign_sel_c10", int'(mux_sel), 1);
      tick();
      #2;
      chk("ign_busy_c11", int'(busy), 0);
      idle_ticks(2);

      // Reset while counter is 3 (cycle 5).
      Data_Valid = 1;
      tick();
      Data_Valid = 0;
      for (int c = 2; c <= 5; c++) tick();
      RST = 0;
      tick();
      #2;
      chk("rst_sel", int'(mux_sel), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_en", int'(ser_en), 0);
      RST = 1;
      idle_ticks(3);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         Data_Valid = ($urandom_range(0, 3) == 0);
         PAR_EN     = $urandom_range(0, 1) == 1;
         RST        = ($urandom_range(0, 199) != 0);
         tick();
      end
      RST = 1;
      idle_ticks(15);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
